wb_string_ctrl: RTL and testbench
=================================

WB_STRING_CTRL -- requirements
Module: wb_string_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: datapath width of GPR, flags, count and pointer values.
REQ-002 Parameter NWP, default 3: number of GPR write ports (port 0 = ALU/CMPS-first, 1 = pointer, 2 = count; ports >= 3 carry WB_EXTRA_DATA).
REQ-003 CLK  in  1: single clock; all state updates on rising edge.
REQ-004 RST  in  1: synchronous, active-high reset.
REQ-005 WB_V  in  1: stage-valid qualifier.
REQ-006 WB_LD_GPR  in  NWP: per-port GPR load requests from decode/control store.
REQ-007 WB_DR  in  3*NWP: destination register numbers, port i at bits [3i+2:3i].
REQ-008 WB_ALU_RESULT, WB_COUNT, WB_CMPS_POINTER, WB_ADDRESS  in  DATA_W each: result, incoming ECX, string pointer, memory address.
REQ-009 WB_EXTRA_DATA  in  DATA_W*max(NWP-3,1): data for ports >= 3.
REQ-010 WB_FLAGS, WB_FLAGS_AFFECTED  in  DATA_W each: new flag values and per-bit update mask.
REQ-011 WB_LD_FLAGS, WB_DCACHE_WRITE, CMPS_FIRST, CMPS_SECOND, REPNE_FIRST  in  1 each: uop controls.
REQ-012 WB_DATASIZE  in  2: 0 byte, 1 word, 2 dword, 3 reserved.
REQ-013 DCACHE_READY  in  1: dcache accepts a write this cycle.
REQ-014 Out_DR, Out_DR_Data, Out_LD_GPR  out  3*NWP, DATA_W*NWP, NWP: validated register-file write ports.
REQ-015 Out_Dcache_Valid, Out_Dcache_Data, Out_Dcache_Address, Out_Datasize  out  1, DATA_W, DATA_W, 2.
REQ-016 Out_Flags  out  DATA_W: architectural flags register.
REQ-017 Out_Stall  out  1: writeback cannot retire this cycle.
REQ-018 Out_Repne_Term  out  1: REPNE loop terminates this cycle.

Function
REQ-019 commit = WB_V & ~Out_Stall; Out_Stall = WB_V & WB_DCACHE_WRITE & ~DCACHE_READY, combinational.
REQ-020 Out_LD_GPR[i] = commit & WB_LD_GPR[i]; Out_Dcache_Valid = commit & WB_DCACHE_WRITE; no state changes in a stalled cycle.
REQ-021 Port 0 data = saved CMPS pointer when CMPS_FIRST, else WB_ALU_RESULT; port 1 = updated pointer; port 2 = count register next value; Out_Dcache_Data = port 0 data.
REQ-022 Updated pointer = WB_CMPS_POINTER +/- step (minus when flags bit 10 DF=1), step 1/2/4 for datasize 0/1/2, 4 for 3, modulo 2^DATA_W.
REQ-023 Saved-pointer register loads updated pointer on commit & CMPS_FIRST, holds otherwise.
REQ-024 Flags: on commit & WB_LD_FLAGS, flags <= (WB_FLAGS & WB_FLAGS_AFFECTED) | (flags & ~WB_FLAGS_AFFECTED); only bits 11,10,7,6,4,2,0 writable, others read 0.
REQ-025 REPNE FSM states IDLE, ACTIVE; IDLE->ACTIVE on commit & REPNE_FIRST, count <= WB_COUNT.
REQ-026 ACTIVE: on commit & CMPS_SECOND, count <= count-1; Out_Repne_Term=1 that cycle if count-1==0 or ZF (bit 6 of flags after this cycle's update) ==1; then ->IDLE.
REQ-027 REPNE_FIRST with WB_COUNT==0: Out_Repne_Term=1 same cycle, stay IDLE, count <= 0.
REQ-028 REPNE_FIRST while ACTIVE: restart, count reloaded, no termination pulse.
REQ-029 Out_Repne_Term is a single-cycle pulse, never asserted when commit=0.

Reset
REQ-030 RST high at a clock edge: flags, count, saved pointer <= 0, FSM <= IDLE; effective mid-loop, discarding the loop.
REQ-031 During RST cycle all Out_LD_GPR, Out_Dcache_Valid, Out_Repne_Term = 0.

Configuration
REQ-032 Macro WB_REPNE_EN: defined -> REQ-025..029 FSM present; undefined -> no FSM/count register, port 2 data = WB_COUNT, Out_Repne_Term tied 0.

Structure
REQ-033 Package wb_pkg holds flag bit indices (OF 11, DF 10, SF 7, ZF 6, AF 4, PF 2, CF 0), writable-flag mask, datasize encodings, FSM state enum.
REQ-034 One sub-module wb_repne_fsm (count register + FSM); rest in top level.

Verification
REQ-035 REPNE_FIRST count=3, three CMPS_SECOND with ZF=0 -> Term on third, port2 data 2,1,0.
REQ-036 Count=5, second iteration sets ZF=1 via flags update -> Term that cycle, FSM IDLE.
REQ-037 DF=1, datasize=2, pointer 0x00000002 -> updated 0xFFFFFFFE; DF=0, size 0, 0xFFFFFFFF -> 0x00000000.
REQ-038 Dcache write with DCACHE_READY=0 for 2 cycles -> Out_Stall=1, no GPR/flag update; READY=1 -> single commit.
REQ-039 Flags=0, WB_FLAGS=0xFFFFFFFF, mask=0x00000041 -> Out_Flags=0x00000041.
REQ-040 RST asserted while ACTIVE count=4 -> next cycle IDLE, count 0, flags 0, no Term.

Source files
------------

// File: rtl/wb_string_ctrl_pkg.sv
// Shared definitions for the string-instruction writeback stage: flag bit
// positions, the writable-flag mask, datasize encodings and REPNE FSM states.
package wb_pkg;

    localparam int FLAG_OF = 11;
    localparam int FLAG_DF = 10;
    localparam int FLAG_SF = 7;
    localparam int FLAG_ZF = 6;
    localparam int FLAG_AF = 4;
    localparam int FLAG_PF = 2;
    localparam int FLAG_CF = 0;

    localparam logic [31:0] FLAGS_WRITABLE = 32'h0000_0CD5;

    typedef enum logic [1:0] {
        DS_BYTE  = 2'd0,
        DS_WORD  = 2'd1,
        DS_DWORD = 2'd2,
        DS_RSVD  = 2'd3
    } datasize_e;

    typedef enum logic {
        REPNE_IDLE   = 1'b0,
        REPNE_ACTIVE = 1'b1
    } repne_state_e;

    // Pointer stride in bytes; the reserved encoding strides like a dword.
    function automatic logic [2:0] ds_step(input logic [1:0] ds);
        logic [2:0] step;
        case (ds)
            DS_BYTE:  step = 3'd1;
            DS_WORD:  step = 3'd2;
            DS_DWORD: step = 3'd4;
            default:  step = 3'd4;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/wb_string_ctrl_repne_fsm.sv
// REPNE loop tracker: holds the remaining count and raises a same-cycle
// termination pulse when the count runs out or ZF becomes set.
module wb_repne_fsm
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic              repne_first,
    input  logic              cmps_second,
    input  logic [DATA_W-1:0] wb_count,
    input  logic              zf_next,
    output logic [DATA_W-1:0] count_next,
    output logic              repne_term
);

    repne_state_e      state_r;
    repne_state_e      state_next_s;
    logic [DATA_W-1:0] count_r;
    logic [DATA_W-1:0] count_dec_s;

    assign count_dec_s = count_r - DATA_W'(1);

    // Next count/state; a REPNE_FIRST always wins and restarts the loop.
    always_comb begin
        state_next_s = state_r;
        count_next   = count_r;
        repne_term   = 1'b0;
        if (commit && repne_first) begin
            count_next = wb_count;
            if (wb_count == '0) begin
                repne_term   = 1'b1;
                state_next_s = REPNE_IDLE;
            end else begin
                state_next_s = REPNE_ACTIVE;
            end
        end else if (commit && cmps_second && (state_r == REPNE_ACTIVE)) begin
            count_next = count_dec_s;
            if ((count_dec_s == '0) || zf_next) begin
                repne_term   = 1'b1;
                state_next_s = REPNE_IDLE;
            end else begin
                state_next_s = REPNE_ACTIVE;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Count and state registers; reset abandons any loop in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= REPNE_IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next;
        end
    end

endmodule

// File: rtl/wb_string_ctrl.sv
// Writeback stage for string instructions (CMPS/REPNE): GPR and dcache write
// qualification, pointer stepping and flags. Optional REPNE loop via WB_REPNE_EN.
module wb_string_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NWP    = 3
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     WB_V,
    input  logic [NWP-1:0]                           WB_LD_GPR,
    input  logic [3*NWP-1:0]                         WB_DR,
    input  logic [DATA_W-1:0]                        WB_ALU_RESULT,
    input  logic [DATA_W-1:0]                        WB_COUNT,
    input  logic [DATA_W-1:0]                        WB_CMPS_POINTER,
    input  logic [DATA_W-1:0]                        WB_ADDRESS,
    input  logic [DATA_W*((NWP > 3) ? (NWP-3) : 1)-1:0] WB_EXTRA_DATA,
    input  logic [DATA_W-1:0]                        WB_FLAGS,
    input  logic [DATA_W-1:0]                        WB_FLAGS_AFFECTED,
    input  logic                                     WB_LD_FLAGS,
    input  logic                                     WB_DCACHE_WRITE,
    input  logic                                     CMPS_FIRST,
    input  logic                                     CMPS_SECOND,
    input  logic                                     REPNE_FIRST,
    input  logic [1:0]                               WB_DATASIZE,
    input  logic                                     DCACHE_READY,
    output logic [3*NWP-1:0]                         Out_DR,
    output logic [DATA_W*NWP-1:0]                    Out_DR_Data,
    output logic [NWP-1:0]                           Out_LD_GPR,
    output logic                                     Out_Dcache_Valid,
    output logic [DATA_W-1:0]                        Out_Dcache_Data,
    output logic [DATA_W-1:0]                        Out_Dcache_Address,
    output logic [1:0]                               Out_Datasize,
    output logic [DATA_W-1:0]                        Out_Flags,
    output logic                                     Out_Stall,
    output logic                                     Out_Repne_Term
);

    localparam logic [DATA_W-1:0] FLAG_MASK = DATA_W'(FLAGS_WRITABLE);

    logic              stall_s;
    logic              commit_s;
    logic [DATA_W-1:0] flags_r;
    logic [DATA_W-1:0] flags_next_s;
    logic [DATA_W-1:0] saved_ptr_r;
    logic [DATA_W-1:0] step_s;
    logic [DATA_W-1:0] ptr_upd_s;
    logic [DATA_W-1:0] port0_s;
    logic [DATA_W-1:0] count_next_s;
    logic              term_s;

    assign stall_s  = WB_V & WB_DCACHE_WRITE & ~DCACHE_READY;
    assign commit_s = WB_V & ~stall_s & ~RST;

    // Pointer steps toward lower addresses when DF is set.
    always_comb begin
        step_s = DATA_W'(ds_step(WB_DATASIZE));
        if (flags_r[FLAG_DF]) begin
            ptr_upd_s = WB_CMPS_POINTER - step_s;
        end else begin
            ptr_upd_s = WB_CMPS_POINTER + step_s;
        end
    end

    // Masked flag merge; non-writable bits are forced to zero.
    always_comb begin
        if (commit_s && WB_LD_FLAGS) begin
            flags_next_s = ((WB_FLAGS & WB_FLAGS_AFFECTED) |
                            (flags_r & ~WB_FLAGS_AFFECTED)) & FLAG_MASK;
        end else begin
            flags_next_s = flags_r;
        end
    end

    // Flags and saved CMPS pointer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_r     <= '0;
            saved_ptr_r <= '0;
        end else begin
            flags_r <= flags_next_s;
            if (commit_s && CMPS_FIRST) begin
                saved_ptr_r <= ptr_upd_s;
            end
        end
    end

    assign port0_s = CMPS_FIRST ? saved_ptr_r : WB_ALU_RESULT;

`ifdef WB_REPNE_EN
    wb_repne_fsm #(
        .DATA_W(DATA_W)
    ) u_repne_fsm (
        .clk        (CLK),
        .rst        (RST),
        .commit     (commit_s),
        .repne_first(REPNE_FIRST),
        .cmps_second(CMPS_SECOND),
        .wb_count   (WB_COUNT),
        .zf_next    (flags_next_s[FLAG_ZF]),
        .count_next (count_next_s),
        .repne_term (term_s)
    );
`else
    logic unused_repne_s;
    assign unused_repne_s = REPNE_FIRST ^ CMPS_SECOND;
    assign count_next_s   = WB_COUNT;
    assign term_s         = 1'b0;
`endif

    for (genvar g = 0; g < NWP; g++) begin : g_port
        if (g == 0) begin : g_alu
            assign Out_DR_Data[g*DATA_W +: DATA_W] = port0_s;
        end else if (g == 1) begin : g_ptr
            assign Out_DR_Data[g*DATA_W +: DATA_W] = ptr_upd_s;
        end else if (g == 2) begin : g_cnt
            assign Out_DR_Data[g*DATA_W +: DATA_W] = count_next_s;
        end else begin : g_extra
            assign Out_DR_Data[g*DATA_W +: DATA_W] = WB_EXTRA_DATA[(g-3)*DATA_W +: DATA_W];
        end
    end

    assign Out_DR             = WB_DR;
    assign Out_LD_GPR         = {NWP{commit_s}} & WB_LD_GPR;
    assign Out_Dcache_Valid   = commit_s & WB_DCACHE_WRITE;
    assign Out_Dcache_Data    = port0_s;
    assign Out_Dcache_Address = WB_ADDRESS;
    assign Out_Datasize       = WB_DATASIZE;
    assign Out_Flags          = flags_r;
    assign Out_Stall          = stall_s;
    assign Out_Repne_Term     = term_s;

endmodule

// File: tb/tb_wb_string_ctrl.sv
// Self-checking bench for wb_string_ctrl: vector table, REPNE corner
// sequences and randomized traffic against a behavioural model.
module tb_wb_string_ctrl;

    localparam logic [31:0] WMASK = 32'h0000_0CD5;
`ifdef WB_REPNE_EN
    localparam bit REPNE_EN = 1'b1;
`else
    localparam bit REPNE_EN = 1'b0;
`endif

    logic        CLK, RST, WB_V;
    logic [2:0]  WB_LD_GPR;
    logic [8:0]  WB_DR;
    logic [31:0] WB_ALU_RESULT, WB_COUNT, WB_CMPS_POINTER, WB_ADDRESS, WB_EXTRA_DATA;
    logic [31:0] WB_FLAGS, WB_FLAGS_AFFECTED;
    logic        WB_LD_FLAGS, WB_DCACHE_WRITE, CMPS_FIRST, CMPS_SECOND, REPNE_FIRST;
    logic [1:0]  WB_DATASIZE;
    logic        DCACHE_READY;
    logic [8:0]  Out_DR;
    logic [95:0] Out_DR_Data;
    logic [2:0]  Out_LD_GPR;
    logic        Out_Dcache_Valid;
    logic [31:0] Out_Dcache_Data, Out_Dcache_Address, Out_Flags;
    logic [1:0]  Out_Datasize;
    logic        Out_Stall, Out_Repne_Term;

    wb_string_ctrl #(.DATA_W(32), .NWP(3)) dut (
        .CLK(CLK), .RST(RST), .WB_V(WB_V), .WB_LD_GPR(WB_LD_GPR), .WB_DR(WB_DR),
        .WB_ALU_RESULT(WB_ALU_RESULT), .WB_COUNT(WB_COUNT),
        .WB_CMPS_POINTER(WB_CMPS_POINTER), .WB_ADDRESS(WB_ADDRESS),
        .WB_EXTRA_DATA(WB_EXTRA_DATA), .WB_FLAGS(WB_FLAGS),
        .WB_FLAGS_AFFECTED(WB_FLAGS_AFFECTED), .WB_LD_FLAGS(WB_LD_FLAGS),
        .WB_DCACHE_WRITE(WB_DCACHE_WRITE), .CMPS_FIRST(CMPS_FIRST),
        .CMPS_SECOND(CMPS_SECOND), .REPNE_FIRST(REPNE_FIRST),
        .WB_DATASIZE(WB_DATASIZE), .DCACHE_READY(DCACHE_READY),
        .Out_DR(Out_DR), .Out_DR_Data(Out_DR_Data), .Out_LD_GPR(Out_LD_GPR),
        .Out_Dcache_Valid(Out_Dcache_Valid), .Out_Dcache_Data(Out_Dcache_Data),
        .Out_Dcache_Address(Out_Dcache_Address), .Out_Datasize(Out_Datasize),
        .Out_Flags(Out_Flags), .Out_Stall(Out_Stall), .Out_Repne_Term(Out_Repne_Term)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive0();
        WB_V = 1'b0; WB_LD_GPR = 3'b000; WB_DR = 9'h0A5;
        WB_ALU_RESULT = 32'h0; WB_COUNT = 32'h0; WB_CMPS_POINTER = 32'h0;
        WB_ADDRESS = 32'h0; WB_EXTRA_DATA = 32'h0; WB_FLAGS = 32'h0;
        WB_FLAGS_AFFECTED = 32'h0; WB_LD_FLAGS = 1'b0; WB_DCACHE_WRITE = 1'b0;
        CMPS_FIRST = 1'b0; CMPS_SECOND = 1'b0; REPNE_FIRST = 1'b0;
        WB_DATASIZE = 2'd0; DCACHE_READY = 1'b1;
    endtask

    // Reset with a would-be-committing uop present; nothing may escape.
    task automatic do_reset();
        drive0();
        RST = 1'b1; WB_V = 1'b1; WB_LD_GPR = 3'b111; WB_DCACHE_WRITE = 1'b1;
        REPNE_FIRST = 1'b1; WB_COUNT = 32'h0; CMPS_SECOND = 1'b1;
        #2;
        chk("rst_ld_gpr", 32'(Out_LD_GPR), 32'h0);
        chk("rst_dcache_valid", 32'(Out_Dcache_Valid), 32'h0);
        chk("rst_term", 32'(Out_Repne_Term), 32'h0);
        tick();
        RST = 1'b0;
        drive0();
        chk("rst_flags", Out_Flags, 32'h0);
    endtask

    typedef struct {
        logic        v, dcw, rdy, ldf;
        logic [31:0] wf, aff, ptr;
        logic [1:0]  ds;
        logic        stall;
        logic [2:0]  ld;
        logic        dv;
        logic [31:0] pupd, fl;
    } vec_t;
    vec_t vt[11];

    // Behavioural model state
    logic [31:0] m_flags, m_saved, m_count;
    bit          m_active;
    logic [31:0] e_flags, e_ptr, e_p0, e_p2, n_count, step;
    logic        e_stall, e_commit, e_term;
    bit          n_active;
    int          steps[4] = '{1, 4, 2, 1};

    initial begin
        steps = '{1, 2, 4, 4};
        RST = 1'b0;
        drive0();
        tick();
        do_reset();

        vt[0]  = '{1'b1,1'b0,1'b0,1'b1, 32'hFFFFFFFF,32'h41,32'h0,2'd0,        1'b0,3'b111,1'b0,32'h1,32'h41};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b1, 32'h400,32'h400,32'h5,2'd0,            1'b0,3'b111,1'b0,32'h6,32'h441};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h2,2'd2,                1'b0,3'b111,1'b0,32'hFFFFFFFE,32'h441};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0,32'h400,32'h10,2'd1,             1'b0,3'b111,1'b0,32'hE,32'h41};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,32'hFFFFFFFF,2'd0,         1'b0,3'b111,1'b0,32'h0,32'h41};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h100,2'd3,              1'b0,3'b111,1'b0,32'h104,32'h41};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b1, 32'h0,32'hFFFFFFFF,32'h20,2'd2,        1'b1,3'b000,1'b0,32'h24,32'h41};
        vt[7]  = '{1'b1,1'b1,1'b0,1'b1, 32'h0,32'hFFFFFFFF,32'h20,2'd2,        1'b1,3'b000,1'b0,32'h24,32'h41};
        vt[8]  = '{1'b1,1'b1,1'b1,1'b1, 32'h0,32'hFFFFFFFF,32'h20,2'd2,        1'b0,3'b111,1'b1,32'h24,32'h0};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b1, 32'hFFFFFFFF,32'hFFFFFFFF,32'h0,2'd0,  1'b0,3'b000,1'b0,32'h1,32'h0};
        vt[10] = '{1'b1,1'b0,1'b0,1'b1, 32'hFFFFFFFF,32'hFFFFFFFF,32'h0,2'd0,  1'b0,3'b111,1'b0,32'h1,32'hCD5};

        for (int i = 0; i < 11; i++) begin
            drive0();
            WB_V = vt[i].v; WB_DCACHE_WRITE = vt[i].dcw; DCACHE_READY = vt[i].rdy;
            WB_LD_FLAGS = vt[i].ldf; WB_FLAGS = vt[i].wf; WB_FLAGS_AFFECTED = vt[i].aff;
            WB_CMPS_POINTER = vt[i].ptr; WB_DATASIZE = vt[i].ds; WB_LD_GPR = 3'b111;
            #2;
            chk($sformatf("vec%0d_stall", i), 32'(Out_Stall), 32'(vt[i].stall));
            chk($sformatf("vec%0d_ld_gpr", i), 32'(Out_LD_GPR), 32'(vt[i].ld));
            chk($sformatf("vec%0d_dcache_valid", i), 32'(Out_Dcache_Valid), 32'(vt[i].dv));
            chk($sformatf("vec%0d_ptr", i), Out_DR_Data[63:32], vt[i].pupd);
            tick();
            chk($sformatf("vec%0d_flags", i), Out_Flags, vt[i].fl);
        end

        // Count 3, three CMPS_SECOND with ZF clear: ends on the third
        do_reset();
        WB_V = 1'b1; REPNE_FIRST = 1'b1; WB_COUNT = 32'h3; WB_LD_GPR = 3'b100;
        #2;
        chk("r3_start_term", 32'(Out_Repne_Term), 32'h0);
        chk("r3_start_cnt", Out_DR_Data[95:64], 32'h3);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive0();
            WB_V = 1'b1; CMPS_SECOND = 1'b1; WB_COUNT = 32'hAA; WB_LD_GPR = 3'b100;
            #2;
            chk($sformatf("r3_cnt%0d", k), Out_DR_Data[95:64],
                REPNE_EN ? ((k < 3) ? 32'(2 - k) : 32'h0) : 32'hAA);
            chk($sformatf("r3_term%0d", k), 32'(Out_Repne_Term), 32'(REPNE_EN && (k == 2)));
            tick();
        end

        // Count 5, ZF set on the second iteration
        do_reset();
        WB_V = 1'b1; REPNE_FIRST = 1'b1; WB_COUNT = 32'h5;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive0();
            WB_V = 1'b1; CMPS_SECOND = 1'b1; WB_COUNT = 32'h55;
            if (k == 1) begin
                WB_LD_FLAGS = 1'b1; WB_FLAGS = 32'h40; WB_FLAGS_AFFECTED = 32'h40;
            end
            #2;
            chk($sformatf("zf_cnt%0d", k), Out_DR_Data[95:64],
                REPNE_EN ? ((k == 0) ? 32'h4 : 32'h3) : 32'h55);
            chk($sformatf("zf_term%0d", k), 32'(Out_Repne_Term), 32'(REPNE_EN && (k == 1)));
            tick();
        end
        chk("zf_flags", Out_Flags, 32'h40);

        // Zero count terminates immediately, only when committing
        drive0();
        REPNE_FIRST = 1'b1; WB_COUNT = 32'h0;
        #2 chk("z_nocommit_term", 32'(Out_Repne_Term), 32'h0);
        WB_V = 1'b1; WB_DCACHE_WRITE = 1'b1; DCACHE_READY = 1'b0;
        #2 chk("z_stall_term", 32'(Out_Repne_Term), 32'h0);
        DCACHE_READY = 1'b1;
        #2 chk("z_commit_term", 32'(Out_Repne_Term), 32'(REPNE_EN));
        tick();

        // Reset mid-loop with non-zero flags and saved pointer
        do_reset();
        WB_V = 1'b1; WB_LD_FLAGS = 1'b1; WB_FLAGS = 32'hFFFFFFFF; WB_FLAGS_AFFECTED = 32'h41;
        CMPS_FIRST = 1'b1; WB_CMPS_POINTER = 32'h1000;
        tick();
        drive0();
        WB_V = 1'b1; CMPS_FIRST = 1'b1; REPNE_FIRST = 1'b1; WB_COUNT = 32'h5;
        #2 chk("mid_saved_ptr", Out_DR_Data[31:0], 32'h1001);
        tick();
        drive0();
        WB_V = 1'b1; CMPS_SECOND = 1'b1;
        tick();
        RST = 1'b1; WB_LD_GPR = 3'b111;
        #2;
        chk("mid_rst_term", 32'(Out_Repne_Term), 32'h0);
        chk("mid_rst_ld", 32'(Out_LD_GPR), 32'h0);
        tick();
        RST = 1'b0;
        chk("mid_rst_flags", Out_Flags, 32'h0);
        drive0();
        WB_V = 1'b1; CMPS_SECOND = 1'b1; CMPS_FIRST = 1'b1; WB_COUNT = 32'h77; WB_ALU_RESULT = 32'h99;
        #2;
        chk("mid_after_term", 32'(Out_Repne_Term), 32'h0);
        chk("mid_after_cnt", Out_DR_Data[95:64], REPNE_EN ? 32'h0 : 32'h77);
        chk("mid_after_saved", Out_DR_Data[31:0], 32'h0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            RST = (i == 0) || ($urandom_range(0, 39) == 0);
            WB_V = ($urandom_range(0, 3) != 0);
            WB_DCACHE_WRITE = ($urandom_range(0, 2) == 0);
            DCACHE_READY = $urandom_range(0, 1);
            WB_LD_GPR = 3'($urandom); WB_DR = 9'($urandom);
            WB_ALU_RESULT = $urandom; WB_ADDRESS = $urandom;
            WB_COUNT = $urandom_range(0, 4);
            WB_CMPS_POINTER = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
            WB_FLAGS = $urandom;
            WB_FLAGS_AFFECTED = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            WB_LD_FLAGS = ($urandom_range(0, 2) == 0);
            CMPS_FIRST = ($urandom_range(0, 3) == 0);
            CMPS_SECOND = $urandom_range(0, 1);
            REPNE_FIRST = ($urandom_range(0, 7) == 0);
            WB_DATASIZE = 2'($urandom);

            e_stall = WB_V & WB_DCACHE_WRITE & ~DCACHE_READY;
            e_commit = WB_V & ~e_stall & ~RST;
            e_flags = (e_commit && WB_LD_FLAGS) ?
                      (((WB_FLAGS & WB_FLAGS_AFFECTED) | (m_flags & ~WB_FLAGS_AFFECTED)) & WMASK) : m_flags;
            step = 32'(steps[WB_DATASIZE]);
            e_ptr = m_flags[10] ? WB_CMPS_POINTER - step : WB_CMPS_POINTER + step;
            e_p0 = CMPS_FIRST ? m_saved : WB_ALU_RESULT;
            n_count = m_count; n_active = m_active; e_term = 1'b0;
            if (e_commit && REPNE_FIRST) begin
                n_count = WB_COUNT; n_active = (WB_COUNT != 0); e_term = (WB_COUNT == 0);
            end else if (e_commit && CMPS_SECOND && m_active) begin
                n_count = m_count - 1;
                e_term = (n_count == 0) || e_flags[6];
                n_active = !e_term;
            end
            if (!REPNE_EN) begin
                e_term = 1'b0;
            end
            e_p2 = REPNE_EN ? n_count : WB_COUNT;

            #2;
            chk("rnd_stall", 32'(Out_Stall), 32'(e_stall));
            chk("rnd_ld_gpr", 32'(Out_LD_GPR), e_commit ? 32'(WB_LD_GPR) : 32'h0);
            chk("rnd_dcache_valid", 32'(Out_Dcache_Valid), 32'(e_commit & WB_DCACHE_WRITE));
            chk("rnd_dcache_data", Out_Dcache_Data, e_p0);
            chk("rnd_dcache_addr", Out_Dcache_Address, WB_ADDRESS);
            chk("rnd_datasize", 32'(Out_Datasize), 32'(WB_DATASIZE));
            chk("rnd_dr", 32'(Out_DR), 32'(WB_DR));
            chk("rnd_port0", Out_DR_Data[31:0], e_p0);
            chk("rnd_port1", Out_DR_Data[63:32], e_ptr);
            chk("rnd_port2", Out_DR_Data[95:64], e_p2);
            chk("rnd_term", 32'(Out_Repne_Term), 32'(e_term));
            tick();

            if (RST) begin
                m_flags = 32'h0; m_saved = 32'h0; m_count = 32'h0; m_active = 1'b0;
            end else begin
                m_flags = e_flags;
                if (e_commit && CMPS_FIRST) m_saved = e_ptr;
                m_count = n_count; m_active = n_active;
            end
            chk("rnd_flags", Out_Flags, m_flags);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
